imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, 7, word-address width of instruction memory.
REQ-002 Parameter: DEPTH, 128, number of imem words; SHALL be <= 2**ADDR_W.
REQ-003 Parameter: NOP_WORD, 32'h00000013, pad value written past the loaded program.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; restarts a load from DONE or ERR.
REQ-007 in_valid  in  1  byte stream valid (from serial receiver).
REQ-008 in_data  in  8  byte stream data.
REQ-009 in_ready  out  1  loader accepts byte this cycle.
REQ-010 imem_we  out  1  instruction-memory write strobe.
REQ-011 imem_addr  out  ADDR_W  word address of write.
REQ-012 imem_wdata  out  32  word written.
REQ-013 cpu_rst  out  1  active-high reset to the CPU core; held until load complete.
REQ-014 done  out  1  load and pad finished.
REQ-015 err  out  1  header word count exceeded DEPTH.

Function
REQ-016 Stream format: 2-byte little-endian word count N, then 4*N bytes, each word little-endian (first byte -> bits 7:0).
REQ-017 Byte transfer SHALL occur only on the cycle where in_valid and in_ready are both 1; in_ready SHALL NOT depend combinationally on in_valid.
REQ-018 States: HDR0, HDR1, DATA, FILL, DONE, ERR.
REQ-019 HDR0: in_ready=1; on transfer latch N[7:0] -> HDR1.
REQ-020 HDR1: in_ready=1; on transfer latch N[15:8]; if N > DEPTH -> ERR; if N == 0 -> FILL; else -> DATA, with word address reset to 0.
REQ-021 DATA: in_ready=1; bytes shift into a 32-bit assembler with a 2-bit byte counter.
REQ-022 On the 4th byte transfer, imem_we SHALL be 1 in the next cycle with imem_wdata = assembled word and imem_addr = current word address; word address then increments.
REQ-023 After the Nth word write, DATA -> FILL; if N == DEPTH, DATA -> DONE (no padding).
REQ-024 FILL: in_ready=0; one write per cycle of NOP_WORD at addresses N..DEPTH-1; after the write to DEPTH-1 -> DONE.
REQ-025 DONE: in_ready=0, done=1, cpu_rst=0, imem_we=0.
REQ-026 ERR: in_ready=0, err=1, cpu_rst=1, no writes.
REQ-027 start in DONE or ERR -> HDR0, clearing done/err and reasserting cpu_rst in the next cycle; start in any other state SHALL be ignored.
REQ-028 cpu_rst SHALL be 1 in every state except DONE.
REQ-029 imem_we SHALL be a single-cycle pulse per word; no address SHALL be written twice per load.
REQ-030 Gaps in in_valid SHALL stall the assembler without loss or duplication.

Reset
REQ-031 rst_n low SHALL immediately force state HDR0, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, done=0, err=0, byte counter and N cleared.
REQ-032 Reset mid-load SHALL abandon the partial word; memory contents already written are not restored.

Structure
REQ-033 State encoding enum, NOP_WORD, and header byte count (2) belong in the shared cpu package alongside the opcode constants.
REQ-034 One sub-module is natural: byte_to_word (shift assembler plus 2-bit counter, emits word_valid); the FSM and address counter stay in imem_loader.

Verification
REQ-035 Stream 02 00 | 93 00 A0 00 | 13 01 30 00 -> writes addr0=00a00093, addr1=00300113, then NOP_WORD at 2..127, done=1, cpu_rst falls on the DONE cycle.
REQ-036 Header 00 00 -> no data bytes accepted; 128 NOP_WORD writes; done=1.
REQ-037 Header 81 00 (N=129, DEPTH=128) -> err=1, cpu_rst=1, in_ready=0, zero writes.
REQ-038 Same stream as REQ-035 with in_valid low on alternate cycles -> identical writes and addresses.
REQ-039 rst_n pulsed low after 6 data bytes, then full REQ-035 stream -> only the post-reset words written to 0 and 1; no stray write.
REQ-040 After DONE, start pulse then header 01 00 and bytes 37 50 34 12 -> addr0=12345037, pad 1..127, done=1 again.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared CPU-side definitions: RV32I opcode constants plus the boot loader's
// state encoding and header format.
package imem_loader_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // addi x0, x0, 0 -- the canonical RV32I no-op used to pad unused memory.
  localparam logic [31:0] NOP_INSN = {25'b0, OPC_OP_IMM};

  localparam int HDR_BYTES = 2;

  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian byte-to-word assembler: four accepted bytes become one
// 32-bit word, presented for exactly one cycle after the fourth byte.
module byte_to_word (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_xfer,
  input  logic [7:0]  i_data,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;
  logic [31:0] r_word;
  logic        r_valid;
  logic [31:0] w_word_next;

  // Earlier bytes move down, so the first byte of a word ends up in bits 7:0.
  assign w_word_next = {i_data, r_shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_xfer) begin
        r_shift <= w_word_next[31:8];
        r_cnt   <= r_cnt + 2'd1;
        if (r_cnt == 2'd3) begin
          r_word  <= w_word_next;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign o_word_valid = r_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed program over a byte stream, writes it
// into instruction memory, pads the rest with NOPs and then releases the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W   = 7,
  parameter int          DEPTH    = 128,
  parameter logic [31:0] NOP_WORD = NOP_INSN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int HDR_BITS = 8 * HDR_BYTES;

  loader_state_t       r_state;
  loader_state_t       w_state_next;
  logic [HDR_BITS-1:0] r_n;
  logic [ADDR_W-1:0]   r_waddr;

  logic [HDR_BITS-1:0] w_hdr_n;
  logic [HDR_BITS-1:0] w_waddr_ext;
  logic                w_last_word;
  logic                w_fill_last;
  logic                w_b2w_clear;
  logic                w_b2w_xfer;
  logic                w_word_valid;
  logic [31:0]         w_word;

  assign w_hdr_n     = {in_data, r_n[7:0]};
  assign w_waddr_ext = HDR_BITS'(r_waddr);
  assign w_last_word = (w_waddr_ext == r_n - HDR_BITS'(1));
  assign w_fill_last = (r_waddr == ADDR_W'(DEPTH - 1));
  assign w_b2w_clear = (r_state != ST_DATA);
  assign w_b2w_xfer  = in_valid && in_ready && (r_state == ST_DATA);

  byte_to_word u_b2w (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_b2w_clear),
    .i_xfer       (w_b2w_xfer),
    .i_data       (in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HDR0;
      r_n     <= '0;
      r_waddr <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_HDR0: if (in_valid) r_n[7:0] <= in_data;
        ST_HDR1: begin
          if (in_valid) begin
            r_n[15:8] <= in_data;
            r_waddr   <= '0;
          end
        end
        // After the last data word the address already points at the first pad slot.
        ST_DATA: if (w_word_valid) r_waddr <= r_waddr + ADDR_W'(1);
        ST_FILL: if (!w_fill_last) r_waddr <= r_waddr + ADDR_W'(1);
        ST_DONE, ST_ERR: begin
          if (start) begin
            r_n     <= '0;
            r_waddr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    imem_we      = 1'b0;
    imem_addr    = r_waddr;
    imem_wdata   = '0;
    case (r_state)
      ST_HDR0: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = ST_HDR1;
      end
      ST_HDR1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (w_hdr_n > HDR_BITS'(DEPTH))   w_state_next = ST_ERR;
          else if (w_hdr_n == '0)           w_state_next = ST_FILL;
          else                              w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        // Stop accepting bytes on the cycle the final word is being written.
        in_ready = !(w_word_valid && w_last_word);
        if (w_word_valid) begin
          imem_we    = 1'b1;
          imem_wdata = w_word;
          if (w_last_word) begin
            w_state_next = (r_n == HDR_BITS'(DEPTH)) ? ST_DONE : ST_FILL;
          end
        end
      end
      ST_FILL: begin
        imem_we    = 1'b1;
        imem_wdata = NOP_WORD;
        if (w_fill_last) w_state_next = ST_DONE;
      end
      ST_DONE, ST_ERR: begin
        if (start) w_state_next = ST_HDR0;
      end
      default: w_state_next = ST_HDR0;
    endcase
  end

  assign done    = (r_state == ST_DONE);
  assign err     = (r_state == ST_ERR);
  assign cpu_rst = (r_state != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of program loads plus
// hand-written sequences for mid-load reset and restart behaviour.
module tb_imem_loader;

  localparam int          DEPTH = 128;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       imem_we;
  logic [6:0] imem_addr;
  logic [31:0] imem_wdata;
  logic       cpu_rst;
  logic       done;
  logic       err;

  imem_loader #(.ADDR_W(7), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [15:0]      n;
    logic [2:0][31:0] w;
    logic             gaps;
  } vec_t;

  wr_t  wrLog[$];
  int   accCount = 0;
  int   viol     = 0;
  int   timeouts = 0;
  int   testsRun = 0;
  int   failCount = 0;
  vec_t vecs[9];

  // Passive monitor: logs every write and flags output-relationship violations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) accCount++;
      if (imem_we) wrLog.push_back('{addr: imem_addr, data: imem_wdata});
      if (cpu_rst !== ~done) viol++;
      if (imem_we && (done || err)) viol++;
      if (done && err) viol++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] expWord(input vec_t v, input int k);
    if (k >= int'(v.n)) return NOP;
    if (v.n > 16'd3)    return 32'hC0DE0000 | 32'(k);
    return v.w[k];
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte was taken.
  task automatic sendByte(input logic [7:0] b, input logic gap);
    int t;
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) timeouts++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int id, input logic doStart, input logic startMid);
    int          base;
    int          acc0;
    int          viol0;
    int          to0;
    int          t;
    int          nw;
    int          bad;
    logic        expErr;
    logic [31:0] w;
    base   = wrLog.size();
    acc0   = accCount;
    viol0  = viol;
    to0    = timeouts;
    expErr = (v.n > 16'(DEPTH));
    if (doStart) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput($sformatf("v%0d.restart{done,err,cpu_rst,in_ready}", id),
                  32'({done, err, cpu_rst, in_ready}), 32'b0011);
    end
    sendByte(v.n[7:0], v.gaps);
    sendByte(v.n[15:8], v.gaps);
    if (!expErr) begin
      for (int i = 0; i < int'(v.n); i++) begin
        w = expWord(v, i);
        for (int b = 0; b < 4; b++) begin
          if (startMid && i == 0 && b == 0) start = 1'b1;
          sendByte(w[8*b +: 8], v.gaps);
          start = 1'b0;
        end
      end
    end
    // Keep offering bytes: none should be taken once the stream is complete.
    in_valid = 1'b1;
    in_data  = 8'hEE;
    t = 0;
    while (!(done || err) && t < 700) begin
      @(negedge clk);
      t++;
    end
    checkOutput($sformatf("v%0d.finishedInTime", id), 32'(done || err), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    nw = wrLog.size() - base;
    checkOutput($sformatf("v%0d.err", id), 32'(err), 32'(expErr));
    checkOutput($sformatf("v%0d.done", id), 32'(done), 32'(!expErr));
    checkOutput($sformatf("v%0d.cpu_rst", id), 32'(cpu_rst), 32'(expErr));
    checkOutput($sformatf("v%0d.in_ready", id), 32'(in_ready), 32'd0);
    checkOutput($sformatf("v%0d.writeCount", id), 32'(nw), expErr ? 32'd0 : 32'(DEPTH));
    checkOutput($sformatf("v%0d.bytesAccepted", id), 32'(accCount - acc0),
                expErr ? 32'd2 : 32'(2 + 4 * int'(v.n)));
    bad = 0;
    for (int k = 0; k < nw && k < DEPTH; k++) begin
      if (wrLog[base+k].addr !== 7'(k) || wrLog[base+k].data !== expWord(v, k)) begin
        if (bad == 0)
          $display("[TB] v%0d write %0d: addr %0d data 0x%0h, wanted addr %0d data 0x%0h",
                   id, k, wrLog[base+k].addr, wrLog[base+k].data, k, expWord(v, k));
        bad++;
      end
    end
    checkOutput($sformatf("v%0d.writeContents", id), 32'(bad), 32'd0);
    checkOutput($sformatf("v%0d.outputInvariants", id), 32'(viol - viol0), 32'd0);
    checkOutput($sformatf("v%0d.byteTimeouts", id), 32'(timeouts - to0), 32'd0);
  endtask

  initial begin
    int base;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset.{in_ready,imem_we,cpu_rst,done,err}",
                32'({in_ready, imem_we, cpu_rst, done, err}), 32'b10100);
    checkOutput("reset.imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("reset.imem_wdata", imem_wdata, 32'd0);

    vecs[0] = '{n: 16'd2,   w: {32'h0, 32'h00300113, 32'h00a00093}, gaps: 1'b0};
    vecs[1] = '{n: 16'd0,   w: '0, gaps: 1'b0};
    vecs[2] = '{n: 16'd129, w: '0, gaps: 1'b0};
    vecs[3] = '{n: 16'd2,   w: {32'h0, 32'h00300113, 32'h00a00093}, gaps: 1'b1};
    vecs[4] = '{n: 16'd1,   w: {32'h0, 32'h0, 32'h12345037}, gaps: 1'b0};
    vecs[5] = '{n: 16'h0100, w: '0, gaps: 1'b0};
    vecs[6] = '{n: 16'd3,   w: {32'hFFFFFFFF, 32'h00000000, 32'hDEADBEEF}, gaps: 1'b1};
    vecs[7] = '{n: 16'd128, w: '0, gaps: 1'b0};
    vecs[8] = '{n: 16'd127, w: '0, gaps: 1'b0};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i, i != 0, 1'b0);

    // Abandon a load after six data bytes: only the first complete word lands.
    base  = wrLog.size();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sendByte(8'h02, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h93, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'hA0, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h13, 1'b0);
    sendByte(8'h01, 1'b0);
    @(posedge clk); #1;
    checkOutput("midReset.preResetWrites", 32'(wrLog.size() - base), 32'd1);
    if (wrLog.size() > base) begin
      checkOutput("midReset.word0Addr", 32'(wrLog[base].addr), 32'd0);
      checkOutput("midReset.word0Data", wrLog[base].data, 32'h00a00093);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.{in_ready,imem_we,cpu_rst,done,err}",
                32'({in_ready, imem_we, cpu_rst, done, err}), 32'b10100);
    base = wrLog.size();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midReset.idleWrites", 32'(wrLog.size() - base), 32'd0);
    checkOutput("midReset.in_ready", 32'(in_ready), 32'd1);
    applyStimulus(vecs[0], 9, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
